image_ram_arbiter: RTL and testbench

Shares the single-port image RAM between three requesters: the JPEG decoder block writer, the histogram/CDF generator reader and the filter controller reader.
- Issues registered per-requester grants; these drive each client's is_image_RAM_available.
- Muxes the granted client's CE/WE/address/data onto the RAM.
- Returns read-valid strobes to the owner of each read.
- Sits between the decoder/histogram/filter clients and the image RAM instance.

---
 rtl/image_ram_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_image_ram_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_ram_arbiter.sv
// image_ram_arbiter: shares one single-port image RAM between the JPEG
// decoder (writer), the histogram/CDF generator (reader) and the filter
// controller (reader). The decoder has fixed priority. The two readers
// alternate round-robin and may be rotated out after a bounded hold time.
// Every change of owner costs one dead HANDOVER cycle.
// Optional build macro: ARB_PROTOCOL_CHECK_EN enables the sticky
// protocol_error monitor. Without it, protocol_error is tied low.
module image_ram_arbiter #(
  parameter int PIXEL_WIDTH             = 8,
  parameter int IMAGE_RAM_ADDRESS_WIDTH = 17,
  parameter int MAX_HOLD_CYCLES         = 256,
  parameter int HOLD_COUNT_WIDTH        = $clog2(MAX_HOLD_CYCLES)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               dec_req,
  input  logic                               hist_req,
  input  logic                               filt_req,
  input  logic                               dec_CE,
  input  logic                               dec_WE,
  input  logic                               hist_CE,
  input  logic                               filt_CE,
  input  logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] dec_address,
  input  logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] hist_address,
  input  logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] filt_address,
  input  logic [PIXEL_WIDTH-1:0]             dec_data,
  output logic                               dec_grant,
  output logic                               hist_grant,
  output logic                               filt_grant,
  output logic                               hist_rd_valid,
  output logic                               filt_rd_valid,
  output logic [PIXEL_WIDTH-1:0]             read_data,
  output logic                               image_RAM_CE,
  output logic                               image_RAM_WE,
  output logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] image_RAM_address,
  output logic [PIXEL_WIDTH-1:0]             image_RAM_data_output,
  input  logic [PIXEL_WIDTH-1:0]             image_RAM_data_input,
  output logic                               protocol_error
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GNT_DEC  = 3'd1;
  localparam logic [2:0] GNT_HIST = 3'd2;
  localparam logic [2:0] GNT_FILT = 3'd3;
  localparam logic [2:0] HANDOVER = 3'd4;

  localparam logic PTR_HIST = 1'b0;
  localparam logic PTR_FILT = 1'b1;

  localparam logic [HOLD_COUNT_WIDTH-1:0] HOLD_LAST = HOLD_COUNT_WIDTH'(MAX_HOLD_CYCLES - 1);
  localparam logic [HOLD_COUNT_WIDTH-1:0] HOLD_ONE  = HOLD_COUNT_WIDTH'(1);

  logic [2:0]                  state_q, state_d;
  logic [2:0]                  select_state;
  logic [HOLD_COUNT_WIDTH-1:0] hold_q, hold_d;
  logic                        ptr_q, ptr_d;
  logic                        dec_grant_q, dec_grant_d;
  logic                        hist_grant_q, hist_grant_d;
  logic                        filt_grant_q, filt_grant_d;
  logic                        hist_rd_valid_q, hist_rd_valid_d;
  logic                        filt_rd_valid_q, filt_rd_valid_d;
  logic                        we_effective;

  // Choose the next owner: decoder first, then the round-robin pointer
  // breaks a tie between the readers, otherwise any single requester.
  always_comb begin
    select_state = IDLE;
    if (dec_req) begin
      select_state = GNT_DEC;
    end else if (hist_req && filt_req) begin
      select_state = (ptr_q == PTR_HIST) ? GNT_HIST : GNT_FILT;
    end else if (hist_req) begin
      select_state = GNT_HIST;
    end else if (filt_req) begin
      select_state = GNT_FILT;
    end
  end

  // Ownership FSM with hold counter. A release or a forced rotation always
  // passes through HANDOVER. A reader that leaves hands priority to the other reader.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE, HANDOVER: begin
        state_d = select_state;
        hold_d  = '0;
      end
      GNT_DEC: begin
        if (!dec_req) begin
          state_d = HANDOVER;
        end
      end
      GNT_HIST: begin
        if (!hist_req || (hold_q == HOLD_LAST && filt_req)) begin
          state_d = HANDOVER;
          ptr_d   = PTR_FILT;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      GNT_FILT: begin
        if (!filt_req || (hold_q == HOLD_LAST && hist_req)) begin
          state_d = HANDOVER;
          ptr_d   = PTR_HIST;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // Grants are decoded from the next state so they are registered outputs.
  always_comb begin
    dec_grant_d  = (state_d == GNT_DEC);
    hist_grant_d = (state_d == GNT_HIST);
    filt_grant_d = (state_d == GNT_FILT);
  end

  // Route the owner's strobes onto the RAM. The readers can never write,
  // and the RAM is parked at zero when nobody owns it.
  always_comb begin
    image_RAM_CE          = 1'b0;
    image_RAM_WE          = 1'b0;
    image_RAM_address     = '0;
    image_RAM_data_output = '0;
    if (dec_grant_q) begin
      image_RAM_CE          = dec_CE;
      image_RAM_WE          = dec_WE;
      image_RAM_address     = dec_address;
      image_RAM_data_output = dec_data;
    end else if (hist_grant_q) begin
      image_RAM_CE      = hist_CE;
      image_RAM_address = hist_address;
    end else if (filt_grant_q) begin
      image_RAM_CE      = filt_CE;
      image_RAM_address = filt_address;
    end
  end

  // Read-valid strobes are delayed one cycle to line up with the RAM's
  // synchronous read data.
  always_comb begin
    we_effective    = dec_grant_q & dec_WE;
    hist_rd_valid_d = hist_grant_q & hist_CE & ~we_effective;
    filt_rd_valid_d = filt_grant_q & filt_CE & ~we_effective;
  end

  // All arbiter state, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      hold_q          <= '0;
      ptr_q           <= PTR_HIST;
      dec_grant_q     <= 1'b0;
      hist_grant_q    <= 1'b0;
      filt_grant_q    <= 1'b0;
      hist_rd_valid_q <= 1'b0;
      filt_rd_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_q          <= hold_d;
      ptr_q           <= ptr_d;
      dec_grant_q     <= dec_grant_d;
      hist_grant_q    <= hist_grant_d;
      filt_grant_q    <= filt_grant_d;
      hist_rd_valid_q <= hist_rd_valid_d;
      filt_rd_valid_q <= filt_rd_valid_d;
    end
  end

  assign dec_grant     = dec_grant_q;
  assign hist_grant    = hist_grant_q;
  assign filt_grant    = filt_grant_q;
  assign hist_rd_valid = hist_rd_valid_q;
  assign filt_rd_valid = filt_rd_valid_q;
  assign read_data     = image_RAM_data_input;

`ifdef ARB_PROTOCOL_CHECK_EN
  logic protocol_error_q, protocol_error_d;

  // Sticky flag for any strobe raised without ownership, or for a write
  // enable raised without a chip enable.
  always_comb begin
    protocol_error_d = protocol_error_q
                     | (dec_CE  & ~dec_grant_q)
                     | (hist_CE & ~hist_grant_q)
                     | (filt_CE & ~filt_grant_q)
                     | (dec_WE  & ~dec_CE);
  end

  // Only reset clears the protocol flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      protocol_error_q <= 1'b0;
    end else begin
      protocol_error_q <= protocol_error_d;
    end
  end

  assign protocol_error = protocol_error_q;
`else
  assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_image_ram_arbiter.sv
// tb_image_ram_arbiter: scoreboard bench for image_ram_arbiter. An
// ownership-level reference model predicts each cycle's outputs and read
// data into queues. A negedge monitor pops those queues and compares them
// with the DUT outputs.
module tb_image_ram_arbiter;

  localparam int PW   = 8;
  localparam int AW   = 17;
  localparam int MAXH = 16;
  localparam int HW   = $clog2(MAXH);

  localparam int OWN_NONE = 0;
  localparam int OWN_DEC  = 1;
  localparam int OWN_HIST = 2;
  localparam int OWN_FILT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_req, hist_req, filt_req;
  logic          dec_CE, dec_WE, hist_CE, filt_CE;
  logic [AW-1:0] dec_address, hist_address, filt_address;
  logic [PW-1:0] dec_data;
  logic          dec_grant, hist_grant, filt_grant;
  logic          hist_rd_valid, filt_rd_valid;
  logic [PW-1:0] read_data;
  logic          image_RAM_CE, image_RAM_WE;
  logic [AW-1:0] image_RAM_address;
  logic [PW-1:0] image_RAM_data_output;
  logic [PW-1:0] image_RAM_data_input;
  logic          protocol_error;

  always #5 clk = ~clk;

  image_ram_arbiter #(
    .PIXEL_WIDTH(PW), .IMAGE_RAM_ADDRESS_WIDTH(AW),
    .MAX_HOLD_CYCLES(MAXH), .HOLD_COUNT_WIDTH(HW)
  ) dut (
    .clk(clk), .rst(rst),
    .dec_req(dec_req), .hist_req(hist_req), .filt_req(filt_req),
    .dec_CE(dec_CE), .dec_WE(dec_WE), .hist_CE(hist_CE), .filt_CE(filt_CE),
    .dec_address(dec_address), .hist_address(hist_address), .filt_address(filt_address),
    .dec_data(dec_data),
    .dec_grant(dec_grant), .hist_grant(hist_grant), .filt_grant(filt_grant),
    .hist_rd_valid(hist_rd_valid), .filt_rd_valid(filt_rd_valid),
    .read_data(read_data),
    .image_RAM_CE(image_RAM_CE), .image_RAM_WE(image_RAM_WE),
    .image_RAM_address(image_RAM_address),
    .image_RAM_data_output(image_RAM_data_output),
    .image_RAM_data_input(image_RAM_data_input),
    .protocol_error(protocol_error)
  );

  // Behavioural single-port RAM with a 1-cycle synchronous read.
  logic [PW-1:0] ram_mem [0:(1<<AW)-1];
  logic [PW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (image_RAM_CE) begin
      if (image_RAM_WE) ram_mem[image_RAM_address] <= image_RAM_data_output;
      else              ram_q <= ram_mem[image_RAM_address];
    end
  end
  assign image_RAM_data_input = ram_q;

  typedef struct packed {
    logic rst, gate, dreq, dce, dwe;
    logic [AW-1:0] da;
    logic [PW-1:0] dd;
    logic hreq, hce;
    logic [AW-1:0] ha;
    logic freq, fce;
    logic [AW-1:0] fa;
  } stim_t;

  typedef struct packed {
    logic dg, hg, fg, hrdv, frdv, ce, we;
    logic [AW-1:0] addr;
    logic [PW-1:0] dout;
    logic perr;
  } exp_t;

  // Reference model: who owns the RAM, not how the arbiter encodes it.
  int            m_owner = OWN_NONE;
  int            m_hold = 0;
  bit            m_ptr_filt = 1'b0;
  bit            m_hrdv = 1'b0, m_frdv = 1'b0, m_perr = 1'b0;
  logic [PW-1:0] m_mem [0:(1<<AW)-1];

  exp_t          expq[$];
  logic [PW-1:0] hq[$];
  logic [PW-1:0] fq[$];
  int            checks = 0;
  int            fails = 0;
  stim_t         s;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pickOwner();
    if (dec_req) return OWN_DEC;
    if (hist_req && filt_req) return m_ptr_filt ? OWN_FILT : OWN_HIST;
    if (hist_req) return OWN_HIST;
    if (filt_req) return OWN_FILT;
    return OWN_NONE;
  endfunction

  // Advance the model across one clock edge using the inputs the DUT sampled.
  task automatic modelEdge();
    bit new_h, new_f;
    if (m_owner == OWN_DEC && dec_CE && dec_WE) m_mem[dec_address] = dec_data;
    if (rst) begin
      m_owner = OWN_NONE; m_hold = 0; m_ptr_filt = 1'b0;
      m_hrdv = 1'b0; m_frdv = 1'b0; m_perr = 1'b0;
      hq.delete(); fq.delete();
      return;
    end
    new_h = (m_owner == OWN_HIST) && hist_CE;
    new_f = (m_owner == OWN_FILT) && filt_CE;
    if (new_h) hq.push_back(m_mem[hist_address]);
    if (new_f) fq.push_back(m_mem[filt_address]);
`ifdef ARB_PROTOCOL_CHECK_EN
    if ((dec_CE && m_owner != OWN_DEC) || (hist_CE && m_owner != OWN_HIST) ||
        (filt_CE && m_owner != OWN_FILT) || (dec_WE && !dec_CE)) m_perr = 1'b1;
`endif
    case (m_owner)
      OWN_NONE: begin m_owner = pickOwner(); m_hold = 0; end
      OWN_DEC:  if (!dec_req) m_owner = OWN_NONE;
      OWN_HIST: begin
        if (!hist_req || (m_hold == MAXH-1 && filt_req)) begin
          m_owner = OWN_NONE; m_ptr_filt = 1'b1;
        end else if (m_hold < MAXH-1) m_hold++;
      end
      default: begin
        if (!filt_req || (m_hold == MAXH-1 && hist_req)) begin
          m_owner = OWN_NONE; m_ptr_filt = 1'b0;
        end else if (m_hold < MAXH-1) m_hold++;
      end
    endcase
    m_hrdv = new_h;
    m_frdv = new_f;
  endtask

  // Wait for an edge, update the model, drive the next inputs and queue the
  // expected outputs for this cycle. With gate set, clients only strobe
  // while they own the RAM.
  task automatic applyStimulus(input stim_t st);
    exp_t e;
    @(posedge clk);
    modelEdge();
    #1;
    rst          = st.rst;
    dec_req      = st.dreq;
    hist_req     = st.hreq;
    filt_req     = st.freq;
    dec_CE       = st.dce & (!st.gate || m_owner == OWN_DEC);
    dec_WE       = st.dwe & (!st.gate || m_owner == OWN_DEC);
    hist_CE      = st.hce & (!st.gate || m_owner == OWN_HIST);
    filt_CE      = st.fce & (!st.gate || m_owner == OWN_FILT);
    dec_address  = st.da;
    dec_data     = st.dd;
    hist_address = st.ha;
    filt_address = st.fa;
    e = '0;
    e.dg = (m_owner == OWN_DEC);
    e.hg = (m_owner == OWN_HIST);
    e.fg = (m_owner == OWN_FILT);
    e.hrdv = m_hrdv;
    e.frdv = m_frdv;
    e.perr = m_perr;
    if (m_owner == OWN_DEC) begin
      e.ce = dec_CE; e.we = dec_WE; e.addr = dec_address; e.dout = dec_data;
    end else if (m_owner == OWN_HIST) begin
      e.ce = hist_CE; e.addr = hist_address;
    end else if (m_owner == OWN_FILT) begin
      e.ce = filt_CE; e.addr = filt_address;
    end
    expq.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("dec_grant", dec_grant, e.dg);
    cmp("hist_grant", hist_grant, e.hg);
    cmp("filt_grant", filt_grant, e.fg);
    cmp("hist_rd_valid", hist_rd_valid, e.hrdv);
    cmp("filt_rd_valid", filt_rd_valid, e.frdv);
    cmp("image_RAM_CE", image_RAM_CE, e.ce);
    cmp("image_RAM_WE", image_RAM_WE, e.we);
    cmp("image_RAM_address", 32'(image_RAM_address), 32'(e.addr));
    cmp("image_RAM_data_output", 32'(image_RAM_data_output), 32'(e.dout));
    cmp("protocol_error", protocol_error, e.perr);
  endtask

  // Monitor: compare the queued cycle expectation and any returned read data.
  always @(negedge clk) begin
    if (expq.size() > 0) checkOutput(expq.pop_front());
    if (hist_rd_valid === 1'b1) begin
      if (hq.size() > 0) cmp("hist_read_data", 32'(read_data), 32'(hq.pop_front()));
      else cmp("hist_rd_valid_unexpected", 32'(hist_rd_valid), 32'd0);
    end
    if (filt_rd_valid === 1'b1) begin
      if (fq.size() > 0) cmp("filt_read_data", 32'(read_data), 32'(fq.pop_front()));
      else cmp("filt_rd_valid_unexpected", 32'(filt_rd_valid), 32'd0);
    end
  end

  initial begin
    bit rd, rh, rf;
    int cnt;
    bit done;
    for (int i = 0; i < (1<<AW); i++) begin
      ram_mem[i] = '0;
      m_mem[i] = '0;
    end
    ram_mem[5] = 8'hA7;
    m_mem[5]   = 8'hA7;
    rst = 1'b1; dec_req = 0; hist_req = 0; filt_req = 0;
    dec_CE = 0; dec_WE = 0; hist_CE = 0; filt_CE = 0;
    dec_address = '0; hist_address = '0; filt_address = '0; dec_data = '0;

    // Reset, then idle for ten cycles.
    s = '0; s.rst = 1'b1; s.gate = 1'b1;
    repeat (3) applyStimulus(s);
    s.rst = 1'b0;
    repeat (10) applyStimulus(s);

    // Filter reads address 5 once and expects the preloaded 0xA7.
    s.freq = 1'b1; s.fce = 1'b1; s.fa = AW'(5);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      applyStimulus(s);
      if (m_owner == OWN_FILT) done = 1'b1;
    end
    if (!done) cmp("filt_grant_timeout", 32'd0, 32'd1);
    s.fce = 1'b0;
    applyStimulus(s);
    @(negedge clk);
    cmp("filt_rd_valid_directed", 32'(filt_rd_valid), 32'd1);
    cmp("filt_read_data_directed", 32'(read_data), 32'hA7);
    cmp("hist_rd_valid_directed", 32'(hist_rd_valid), 32'd0);
    s.freq = 1'b0;
    repeat (3) applyStimulus(s);

    // Decoder and filter request together. The decoder writes 64 pixels and then releases.
    s.dreq = 1'b1; s.freq = 1'b1; s.dce = 1'b1; s.dwe = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 64; i++) begin
      s.da = AW'(cnt);
      s.dd = PW'(cnt);
      applyStimulus(s);
      if (m_owner == OWN_DEC) cnt++;
    end
    if (cnt != 64) cmp("dec_write_timeout", 32'(cnt), 32'd64);
    s.dreq = 1'b0; s.dce = 1'b0; s.dwe = 1'b0;
    repeat (5) applyStimulus(s);
    s.freq = 1'b0;
    repeat (3) applyStimulus(s);

    // Both readers request continuously, which forces rotation on the hold limit.
    s.hreq = 1'b1; s.freq = 1'b1;
    for (int i = 0; i < 75; i++) begin
      s.hce = 1'($urandom_range(0, 1)); s.ha = AW'($urandom_range(0, 255));
      s.fce = 1'($urandom_range(0, 1)); s.fa = AW'($urandom_range(0, 255));
      applyStimulus(s);
    end
    s = '0; s.gate = 1'b1;
    repeat (3) applyStimulus(s);

    // Histogram alone (the pointer moves to FILT), then histogram again.
    // Reset is applied while a read is in flight.
    s.hreq = 1'b1;
    repeat (4) applyStimulus(s);
    s.hreq = 1'b0;
    repeat (2) applyStimulus(s);
    s.hreq = 1'b1;
    repeat (3) applyStimulus(s);
    s.hce = 1'b1; s.ha = AW'(10);
    applyStimulus(s);
    s.hce = 1'b0; s.rst = 1'b1;
    applyStimulus(s);
    s.rst = 1'b0; s.freq = 1'b1;
    repeat (6) applyStimulus(s);
    s = '0; s.gate = 1'b1;
    repeat (3) applyStimulus(s);

    // Stray histogram strobe without ownership, then reset.
    s.gate = 1'b0; s.hce = 1'b1;
    applyStimulus(s);
    s.hce = 1'b0; s.gate = 1'b1;
    repeat (5) applyStimulus(s);
    s.rst = 1'b1;
    applyStimulus(s);
    s.rst = 1'b0;
    applyStimulus(s);

    // Randomised traffic with occasional stray strobes and resets.
    rd = 0; rh = 0; rf = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!rd) rd = ($urandom_range(0, 7) == 0); else rd = ($urandom_range(0, 9) != 0);
      if (!rh) rh = ($urandom_range(0, 5) == 0); else rh = ($urandom_range(0, 24) != 0);
      if (!rf) rf = ($urandom_range(0, 5) == 0); else rf = ($urandom_range(0, 24) != 0);
      s.rst  = ($urandom_range(0, 299) == 0);
      s.gate = ($urandom_range(0, 49) != 0);
      s.dreq = rd; s.hreq = rh; s.freq = rf;
      s.dce  = 1'($urandom_range(0, 1));
      s.dwe  = s.dce & ($urandom_range(0, 9) < 7);
      s.da   = AW'($urandom_range(0, 255));
      s.dd   = PW'($urandom);
      s.hce  = 1'($urandom_range(0, 1));
      s.ha   = AW'($urandom_range(0, 255));
      s.fce  = 1'($urandom_range(0, 1));
      s.fa   = AW'($urandom_range(0, 255));
      applyStimulus(s);
    end
    s = '0; s.gate = 1'b1;
    repeat (4) applyStimulus(s);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    #1;
    cmp("expect_queue_drained", 32'(expq.size()), 32'd0);
    cmp("read_queues_drained", 32'(hq.size() + fq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
